// File: rtl/al_map_stream_mux.sv
// al_map_stream_mux: registered CH:1 stream multiplexer with per-packet grant lock.
// Selection is by external sel (MODE=0) or round-robin (MODE=1); the grant is held
// until the last beat of the packet has been accepted.
// Optional macro AL_STREAM_MUX_SKID_EN adds a 1-entry skid buffer and makes in_ready
// a register with no combinational path from out_ready.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   in_data/valid/last      CH input channels, channel k at in_data[k*W +: W]
//   in_ready                per-channel accept
//   sel                     channel select (MODE=0 only)
//   out_data/last/ch/valid  registered output beat and its source channel
//   out_ready               sink accept
module al_map_stream_mux #(
    parameter int unsigned CH   = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = 0,
    localparam int unsigned SW  = (CH > 2) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH-1:0]   in_last,
    output logic [CH-1:0]   in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    typedef enum logic [0:0] {IDLE, LOCK} state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  grant, grant_nxt;
    logic [SW-1:0]  ptr, ptr_nxt;
    logic           req;
    logic [SW-1:0]  req_ch;
    logic [SW-1:0]  idx;
    logic [W-1:0]   gdata;
    logic           gvalid, glast;
    logic           out_free;
    logic           can_take;
    logic           acc;
    logic [CH-1:0]  in_ready_c;

    assign out_free = !out_valid || out_ready;

    // Granted-channel payload mux
    always_comb begin
        gdata  = '0;
        gvalid = in_valid[grant];
        glast  = in_last[grant];
        for (int unsigned k = 0; k < CH; k++) begin
            if (grant == SW'(k)) gdata = in_data[k*W +: W];
        end
    end

    // Arbitration request: external select or first valid channel from ptr
    always_comb begin
        req    = 1'b0;
        req_ch = '0;
        idx    = '0;
        if (MODE == 0) begin
            // An unknown sel fails this compare, so no grant is made
            if (32'(sel) < CH) begin
                if (in_valid[sel]) begin
                    req    = 1'b1;
                    req_ch = sel;
                end
            end
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                idx = SW'((32'(ptr) + i) % CH);
                if (!req && in_valid[idx]) begin
                    req    = 1'b1;
                    req_ch = idx;
                end
            end
        end
    end

    // Next-state, grant, pointer and in_ready
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        ptr_nxt    = ptr;
        in_ready_c = '0;
        acc        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    grant_nxt = req_ch;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                in_ready_c[grant] = can_take;
                acc = gvalid && can_take;
                if (acc && glast) begin
                    state_nxt = IDLE;
                    if (MODE != 0) ptr_nxt = SW'((32'(grant) + 32'd1) % CH);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef AL_STREAM_MUX_SKID_EN
    logic           skid_full, skid_full_nxt;
    logic [W-1:0]   skid_data;
    logic           skid_last;
    logic [SW-1:0]  skid_ch;
    logic [CH-1:0]  in_ready_q, in_ready_nxt;

    assign can_take = in_ready_q[grant];
    assign in_ready = in_ready_q;

    // Skid occupancy and registered in_ready for the coming cycle
    always_comb begin
        skid_full_nxt = skid_full ? !out_free : (acc && !out_free);
        in_ready_nxt  = '0;
        if (state_nxt == LOCK && !skid_full_nxt) in_ready_nxt[grant_nxt] = 1'b1;
    end

    // Output register fed from the skid first, then from the input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_ch     <= '0;
            skid_full  <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            skid_ch    <= '0;
            in_ready_q <= '0;
        end else begin
            if (out_free) begin
                if (skid_full) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_last  <= skid_last;
                    out_ch    <= skid_ch;
                end else if (acc) begin
                    out_valid <= 1'b1;
                    out_data  <= gdata;
                    out_last  <= glast;
                    out_ch    <= grant;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (acc) begin
                skid_data <= gdata;
                skid_last <= glast;
                skid_ch   <= grant;
            end
            skid_full  <= skid_full_nxt;
            in_ready_q <= in_ready_nxt;
        end
    end
`else
    assign can_take = out_free;
    assign in_ready = in_ready_c;

    // Output register: load on accept, clear when drained with nothing behind it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            if (acc) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_last  <= glast;
                out_ch    <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_al_map_stream_mux.sv
// Directed bench for al_map_stream_mux: one MODE=0 and one MODE=1 instance share stimulus.
module tb_al_map_stream_mux;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_last;
    logic [SW-1:0]   sel;
    logic            out_ready;

    logic [CH-1:0]   in_ready0, in_ready1;
    logic [W-1:0]    out_data0, out_data1;
    logic            out_last0, out_last1;
    logic [SW-1:0]   out_ch0, out_ch1;
    logic            out_valid0, out_valid1;

    int checks = 0;
    int errors = 0;

    al_map_stream_mux #(.CH(CH), .W(W), .MODE(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready0), .sel(sel), .out_data(out_data0),
        .out_last(out_last0), .out_ch(out_ch0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    al_map_stream_mux #(.CH(CH), .W(W), .MODE(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready1), .sel(sel), .out_data(out_data1),
        .out_last(out_last1), .out_ch(out_ch1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = 32'hE3E2E1E0;
        sel       = '0;
        out_ready = 1'b1;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({out_valid0, out_last0, out_ch0, out_data0, in_ready0} !== 15'h0) begin
            errors++;
            $display("FAIL reset_dut0: got %h required 0", {out_valid0, out_last0, out_ch0, out_data0, in_ready0});
        end
        checks++;
        if ({out_valid1, out_last1, out_ch1, out_data1, in_ready1} !== 15'h0) begin
            errors++;
            $display("FAIL reset_dut1: got %h required 0", {out_valid1, out_last1, out_ch1, out_data1, in_ready1});
        end
    endtask

    task automatic test_sel_packet();
        do_reset();
        sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'h11);
        #1;
        checks++;
        if (in_ready0 !== 4'b0000) begin errors++; $display("FAIL sel_idle_ready: got %b required 0000", in_ready0); end
        step();
        checks++;
        if ({out_valid0, in_ready0} !== 5'b0_0100) begin errors++; $display("FAIL sel_lock_ready: got %b required 00100", {out_valid0, in_ready0}); end
        step();
        checks++;
        if ({out_valid0, out_last0, out_ch0, out_data0} !== {1'b1, 1'b0, 2'd2, 8'h11}) begin
            errors++; $display("FAIL sel_beat1: got %h required %h", {out_valid0, out_last0, out_ch0, out_data0}, {1'b1, 1'b0, 2'd2, 8'h11});
        end
        checks++;
        if (in_ready0 !== 4'b0100) begin errors++; $display("FAIL sel_ready_only_ch2: got %b required 0100", in_ready0); end
        set_ch(2, 8'h22); in_last = 4'b0100;
        step();
        checks++;
        if ({out_valid0, out_last0, out_ch0, out_data0} !== {1'b1, 1'b1, 2'd2, 8'h22}) begin
            errors++; $display("FAIL sel_beat2: got %h required %h", {out_valid0, out_last0, out_ch0, out_data0}, {1'b1, 1'b1, 2'd2, 8'h22});
        end
        in_valid = '0; in_last = '0;
        #1;
        checks++;
        if (in_ready0 !== 4'b0000) begin errors++; $display("FAIL sel_after_last_ready: got %b required 0000", in_ready0); end
        step();
        checks++;
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL sel_drain: got %b required 0", out_valid0); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_v;
        logic [1:0] exp_ch [8];
        logic [7:0] ch_data [4];
        exp_v = 8'b1010_1010;
        exp_ch = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
        ch_data = '{8'h10, 8'h21, 8'h00, 8'h43};
        do_reset();
        in_valid = 4'b1011; in_last = 4'b1011;
        set_ch(0, 8'h10); set_ch(1, 8'h21); set_ch(3, 8'h43);
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (out_valid1 !== exp_v[i]) begin
                errors++; $display("FAIL rr_valid[%0d]: got %b required %b", i, out_valid1, exp_v[i]);
            end
            if (exp_v[i]) begin
                checks++;
                if ({out_ch1, out_data1} !== {exp_ch[i], ch_data[exp_ch[i]]}) begin
                    errors++; $display("FAIL rr_beat[%0d]: got ch %0d data %h required ch %0d data %h",
                                       i, out_ch1, out_data1, exp_ch[i], ch_data[exp_ch[i]]);
                end
            end
        end
        in_valid = '0; in_last = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        sel = 2'd0; in_valid = 4'b0001; set_ch(0, 8'hA0);
        step();
        step();
        checks++;
        if ({out_valid0, out_last0, out_ch0, out_data0} !== {1'b1, 1'b0, 2'd0, 8'hA0}) begin
            errors++; $display("FAIL bp_first: got %h required %h", {out_valid0, out_last0, out_ch0, out_data0}, {1'b1, 1'b0, 2'd0, 8'hA0});
        end
        out_ready = 1'b0; set_ch(0, 8'hA1);
        #1;
        checks++;
        if (in_ready0 !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready: got %b required 0000", in_ready0); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid0, out_data0} !== {1'b1, 8'hA0}) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h required %h", i, {out_valid0, out_data0}, {1'b1, 8'hA0});
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 4'b0001) begin errors++; $display("FAIL bp_resume_ready: got %b required 0001", in_ready0); end
        step();
        checks++;
        if ({out_valid0, out_last0, out_data0} !== {1'b1, 1'b0, 8'hA1}) begin
            errors++; $display("FAIL bp_second: got %h required %h", {out_valid0, out_last0, out_data0}, {1'b1, 1'b0, 8'hA1});
        end
        set_ch(0, 8'hA2); in_last = 4'b0001;
        step();
        checks++;
        if ({out_valid0, out_last0, out_data0} !== {1'b1, 1'b1, 8'hA2}) begin
            errors++; $display("FAIL bp_third: got %h required %h", {out_valid0, out_last0, out_data0}, {1'b1, 1'b1, 8'hA2});
        end
        in_valid = '0; in_last = '0;
        step();
        checks++;
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b required 0", out_valid0); end
    endtask

    task automatic test_lock();
        logic [7:0] beats [3];
        beats = '{8'hB0, 8'hB1, 8'hB2};
        do_reset();
        sel = 2'd1; in_valid = 4'b1010; in_last = 4'b1000;
        set_ch(1, 8'hB0); set_ch(3, 8'hC3);
        step();
        sel = 2'd3;
        #1;
        checks++;
        if (in_ready0 !== 4'b0010) begin errors++; $display("FAIL lock_ready: got %b required 0010", in_ready0); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid0, out_last0, out_ch0, out_data0} !== {1'b1, (i == 2), 2'd1, beats[i]}) begin
                errors++; $display("FAIL lock_beat[%0d]: got %h required %h", i,
                                   {out_valid0, out_last0, out_ch0, out_data0}, {1'b1, (i == 2), 2'd1, beats[i]});
            end
            if (i == 0) set_ch(1, 8'hB1);
            if (i == 1) begin set_ch(1, 8'hB2); in_last = 4'b1010; end
        end
        in_valid = 4'b1000;
        #1;
        checks++;
        if (in_ready0 !== 4'b0000) begin errors++; $display("FAIL lock_gap_ready: got %b required 0000", in_ready0); end
        step();
        checks++;
        if ({out_valid0, in_ready0} !== 5'b0_1000) begin errors++; $display("FAIL lock_regrant: got %b required 01000", {out_valid0, in_ready0}); end
        step();
        checks++;
        if ({out_valid0, out_last0, out_ch0, out_data0} !== {1'b1, 1'b1, 2'd3, 8'hC3}) begin
            errors++; $display("FAIL lock_ch3: got %h required %h", {out_valid0, out_last0, out_ch0, out_data0}, {1'b1, 1'b1, 2'd3, 8'hC3});
        end
        in_valid = '0; in_last = '0;
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        in_valid = 4'b0100; in_last = 4'b0100; set_ch(2, 8'h52);
        step();
        step();
        checks++;
        if ({out_valid1, out_ch1, out_data1} !== {1'b1, 2'd2, 8'h52}) begin
            errors++; $display("FAIL rst_pre_pkt: got %h required %h", {out_valid1, out_ch1, out_data1}, {1'b1, 2'd2, 8'h52});
        end
        in_valid = 4'b0010; in_last = 4'b0000; set_ch(1, 8'h61);
        step();
        step();
        checks++;
        if ({out_valid1, out_ch1, out_data1} !== {1'b1, 2'd1, 8'h61}) begin
            errors++; $display("FAIL rst_beat1: got %h required %h", {out_valid1, out_ch1, out_data1}, {1'b1, 2'd1, 8'h61});
        end
        set_ch(1, 8'h62);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid1, in_ready1, out_data1} !== 13'h0) begin
            errors++; $display("FAIL rst_async: got %h required 0", {out_valid1, in_ready1, out_data1});
        end
        step();
        resetn = 1'b1;
        in_valid = 4'b1001; in_last = 4'b1001; set_ch(0, 8'h70); set_ch(3, 8'h73);
        step();
        step();
        checks++;
        if ({out_valid1, out_last1, out_ch1, out_data1} !== {1'b1, 1'b1, 2'd0, 8'h70}) begin
            errors++; $display("FAIL rst_ptr0: got %h required %h", {out_valid1, out_last1, out_ch1, out_data1}, {1'b1, 1'b1, 2'd0, 8'h70});
        end
        in_valid = '0; in_last = '0;
    endtask

`ifdef AL_STREAM_MUX_SKID_EN
    task automatic test_skid_toggle();
        int sent;
        int rcv;
        logic [CH-1:0] ir_before;
        logic acc;
        logic take;
        sent = 0;
        rcv  = 0;
        do_reset();
        sel = 2'd0; in_valid = 4'b0001; set_ch(0, 8'h60);
        for (int cyc = 0; cyc < 80 && rcv < 6; cyc++) begin
            @(negedge clk);
            ir_before = in_ready0;
            out_ready = (cyc % 2 == 0);
            #1;
            checks++;
            if (in_ready0 !== ir_before) begin
                errors++; $display("FAIL skid_ready_comb[%0d]: got %b required %b", cyc, in_ready0, ir_before);
            end
            acc  = in_valid[0] & in_ready0[0];
            take = out_valid0 & out_ready;
            if (take) begin
                checks++;
                if ({out_last0, out_data0} !== {(rcv == 5), 8'(8'h60 + rcv)}) begin
                    errors++; $display("FAIL skid_beat[%0d]: got %h required %h", rcv,
                                       {out_last0, out_data0}, {(rcv == 5), 8'(8'h60 + rcv)});
                end
                rcv++;
            end
            step();
            if (acc) begin
                sent++;
                if (sent < 6) begin
                    set_ch(0, 8'(8'h60 + sent));
                    in_last = (sent == 5) ? 4'b0001 : 4'b0000;
                end else begin
                    in_valid = '0; in_last = '0;
                end
            end
        end
        checks++;
        if (rcv !== 6) begin errors++; $display("FAIL skid_count: got %0d required 6", rcv); end
        out_ready = 1'b1;
        in_valid = '0; in_last = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_sel_packet();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_midpacket();
`ifdef AL_STREAM_MUX_SKID_EN
        test_skid_toggle();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/al_map_stream_mux.md
Name: al_map_stream_mux

Overview:
- Parametrised, registered N:1 stream multiplexer; successor to the combinational 4:1 mux cell.
- Selects one of CH input channels, W bits wide, each with a valid/ready/last handshake, and forwards it to a single registered output.
- Arbitration is either by external select or by round-robin, with the grant locked for a whole packet.
- Used in the simulation library and in RTL wherever several CPU-side streams share one sink (debug/UART/trace).

Parameters:
- CH, 4, number of input channels (2..16).
- W, 8, data width per channel (1..64).
- MODE, 0, 0 = external select (sel port), 1 = round-robin arbitration.
- SW, derived localparam = clog2(CH), minimum 1; width of sel and out_ch.

Ports:
- clk  input  1  clock, all logic rising-edge.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  CH*W  channel k occupies bits [k*W +: W].
- in_valid  input  CH  per-channel beat valid.
- in_last  input  CH  per-channel last beat of packet.
- in_ready  output  CH  per-channel beat accepted when in_valid[k] & in_ready[k].
- sel  input  SW  channel select, used only when MODE=0.
- out_data  output  W  registered data.
- out_last  output  1  registered last flag.
- out_ch  output  SW  channel index the current output beat came from.
- out_valid  output  1  output beat valid.
- out_ready  input  1  sink accepts beat when out_valid & out_ready.

Behaviour:
- Reset, asynchronous on resetn low: out_valid=0, out_data=0, out_last=0, out_ch=0, in_ready=0, FSM=IDLE, RR pointer=0, skid empty.
- FSM states are IDLE and LOCK.
- IDLE, MODE=0: sample sel. If sel<CH and in_valid[sel], set grant=sel and go to LOCK next cycle. If sel>=CH, no grant and stay IDLE.
- IDLE, MODE=1: grant the first channel with in_valid set, searching ptr, ptr+1, ... mod CH. Go to LOCK next cycle. No valid channel: stay IDLE.
- LOCK: in_ready[grant] = !out_valid | out_ready. All other in_ready bits are 0.
- On an accepted beat, the output register loads data, last, and out_ch=grant; out_valid=1. Latency is 1 cycle from input acceptance to out_valid.
- On an accepted beat with in_last=1: return to IDLE next cycle. MODE=1 sets ptr=(grant+1) mod CH.
- In IDLE, every in_ready bit is 0. Each packet boundary therefore costs exactly one arbitration cycle.
- Full throughput inside a packet: one beat per cycle while out_ready=1.
- Output holds out_data/out_last/out_ch stable while out_valid & !out_ready. No beat is ever dropped or duplicated.
- out_valid clears when a beat is accepted at the output and no new input beat is accepted in the same cycle.
- A change of sel while in LOCK is ignored until the packet ends.
- A deasserted in_valid on the granted channel during LOCK inserts a bubble; the lock is kept.
- resetn asserted mid-packet: the packet is abandoned and state returns to reset values. The next packet is arbitrated from ptr=0.
- X on sel (simulation only): no grant is made and the FSM stays IDLE.

Optional Feature:
- Macro: AL_STREAM_MUX_SKID_EN.
- Defined: adds a 1-entry skid buffer. in_ready[grant] = !skid_full, registered, with no combinational path from out_ready.
  - An input beat accepted while the output stalls goes into the skid.
  - The skid drains to the output before any new input beat.
  - Throughput and 1-cycle latency are unchanged.
- Not defined: no skid. in_ready depends combinationally on out_ready as specified under LOCK.

Test Plan:
1. MODE=0, CH=4, W=8: sel=2; ch2 sends 0x11,0x22(last) with out_ready=1 -> out_data 0x11 then 0x22, out_ch=2, out_last on 2nd beat, each 1 cycle after acceptance. in_ready[0,1,3] stay 0.
2. MODE=1: ch0, ch1 and ch3 all valid with 1-beat packets -> output order ch0, ch1, ch3, ch0, with one idle cycle between packets.
3. Backpressure: out_ready=0 for 3 cycles mid-packet (0xA0,0xA1,0xA2) -> out_data holds 0xA0, no loss or duplication, stream resumes 0xA1, 0xA2.
4. Lock: sel changes 1->3 during a 3-beat ch1 packet -> all 3 beats from ch1; ch3 is granted only after the last beat plus one cycle.
5. Reset: resetn pulsed low during beat 2 of 4 -> out_valid=0 and in_ready=0 immediately (asynchronous). After release, MODE=1 grants ch0 first.
6. With AL_STREAM_MUX_SKID_EN: toggle out_ready every cycle over a 6-beat packet -> all 6 beats delivered in order; in_ready never toggles in the same cycle as out_ready.
